// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tdm_pkg
// Purpose  : Shared defaults and state encoding for the 8:1 TDM channel path
//            (transmit mux and receive demux).
// Revision : 1.0 - initial release
// ============================================================================
package tdm_pkg;

  // Default frame geometry: 8 one-bit slots per frame
  localparam int TDM_N_CH  = 8;
  localparam int TDM_SEL_W = 3;
  localparam int TDM_DW    = 1;
  localparam int TDM_ERR_W = 8;

  // Frame alignment state: hunting for slot 0, or aligned
  typedef enum logic [0:0] {
    ST_HUNT = 1'b0,
    ST_LOCK = 1'b1
  } tdm_state_e;

endpackage : tdm_pkg
`default_nettype wire

// File: rtl/tdm_slot_counter.sv
`default_nettype none
// ============================================================================
// Module   : tdm_slot_counter
// Purpose  : Slot index counter for the TDM demux. Clear and load-to-1 take
//            priority over increment; wrap flags the last slot of a frame.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_slot_counter #(
  parameter int N_CH  = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             load1_i,
  input  logic             clr_i,
  output logic [SEL_W-1:0] cnt_o,
  output logic             wrap_o
);

  logic [SEL_W-1:0] cnt_q;

  // Slot index register; N_CH is a power of two so increment wraps naturally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load1_i) begin
      cnt_q <= SEL_W'(1);
    end else if (inc_i) begin
      cnt_q <= cnt_q + SEL_W'(1);
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = (cnt_q == SEL_W'(N_CH - 1));

endmodule : tdm_slot_counter
`default_nettype wire

// File: rtl/tdm_demux_8ch.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux_8ch
// Purpose  : Receive side of the 8:1 TDM path. Hunts for frame alignment on
//            frame_sync, deserialises slots into shadow registers and presents
//            each complete frame in parallel with a one-cycle valid strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_demux_8ch
  import tdm_pkg::*;
#(
  parameter int N_CH  = TDM_N_CH,
  parameter int SEL_W = TDM_SEL_W,
  parameter int DW    = TDM_DW,
  parameter int ERR_W = TDM_ERR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DW-1:0]        din,
  input  logic                 din_valid,
  input  logic                 frame_sync,
  output logic [N_CH*DW-1:0]   frame_out,
  output logic                 frame_valid,
  output logic [SEL_W-1:0]     slot,
  output logic                 locked,
  output logic                 sync_err,
  output logic [ERR_W-1:0]     err_cnt
);

  tdm_state_e                state_q;
  // Slots 0..N_CH-2; the last slot goes straight from din into frame_out
  logic [(N_CH-1)*DW-1:0]    shadow_q;
  logic [N_CH*DW-1:0]        frame_out_q;
  logic                      frame_valid_q;
  logic                      sync_err_q;
  logic [ERR_W-1:0]          err_cnt_q;

  logic [SEL_W-1:0]          slot_q;
  logic                      slot_wrap;
  logic                      slot_zero;
  logic                      cnt_inc;
  logic                      cnt_load1;
  logic                      cnt_clr;
  logic                      sync_err_d;
  logic                      frame_done_d;
  logic [ERR_W-1:0]          err_cnt_d;

  tdm_slot_counter #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_slot_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (cnt_inc),
    .load1_i (cnt_load1),
    .clr_i   (cnt_clr),
    .cnt_o   (slot_q),
    .wrap_o  (slot_wrap)
  );

  assign slot_zero = (slot_q == '0);

  // Per-sample decode: slot counter control, alignment errors and frame completion
  always_comb begin
    cnt_inc      = 1'b0;
    cnt_load1    = 1'b0;
    cnt_clr      = 1'b0;
    sync_err_d   = 1'b0;
    frame_done_d = 1'b0;
    if (din_valid) begin
      if (frame_sync) begin
        // Any accepted sync sample starts a new frame at slot 1
        cnt_load1  = 1'b1;
        sync_err_d = (state_q == ST_LOCK) && !slot_zero;
      end else if (state_q == ST_LOCK) begin
        if (slot_zero) begin
          // Expected a sync here: alignment lost
          cnt_clr    = 1'b1;
          sync_err_d = 1'b1;
        end else begin
          cnt_inc      = 1'b1;
          frame_done_d = slot_wrap;
        end
      end
    end
    err_cnt_d = (sync_err_d && (err_cnt_q != {ERR_W{1'b1}})) ? err_cnt_q + ERR_W'(1) : err_cnt_q;
  end

  // Alignment FSM with shadow capture, output latch and error counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_HUNT;
      shadow_q      <= '0;
      frame_out_q   <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      frame_valid_q <= frame_done_d;
      sync_err_q    <= sync_err_d;
      err_cnt_q     <= err_cnt_d;
      if (frame_done_d) begin
        frame_out_q <= {din, shadow_q};
      end
      if (din_valid) begin
        if (frame_sync) begin
          shadow_q[DW-1:0] <= din;
          state_q          <= ST_LOCK;
        end else if (state_q == ST_LOCK) begin
          if (slot_zero) begin
            state_q <= ST_HUNT;
          end else begin
            for (int k = 1; k < N_CH - 1; k++) begin
              if (slot_q == SEL_W'(k)) begin
                shadow_q[k*DW +: DW] <= din;
              end
            end
          end
        end
      end
    end
  end

  assign frame_out   = frame_out_q;
  assign frame_valid = frame_valid_q;
  assign slot        = slot_q;
  assign locked      = (state_q == ST_LOCK);
  assign sync_err    = sync_err_q;
  assign err_cnt     = err_cnt_q;

endmodule : tdm_demux_8ch
`default_nettype wire
